// File: rtl/stage_5.sv
// ---------------------------------------------------------------------------
// stage_5 -- write-back stage of the pipeline.
//
// Holds the MEM/WB pipeline register, owns the 32 x 32 architectural register
// file, commits retiring instructions into it, and counts committed
// instructions. Register reads for stage_2 see a write-through bypass of
// the pending MEM/WB write. The pending write is also exported for stage_3
// forwarding.
//
// Ports
//   clk, rst_n               pipeline clock, asynchronous active-low reset
//   i_valid                  a retiring instruction is on the stage_4 outputs
//   i_mem_out, i_alu_out     load data / ALU result from stage_4
//   i_rd_num                 destination register number
//   i_op_type                1 = write back i_mem_out, 0 = write back i_alu_out
//   i_stall                  hold MEM/WB, no commit on this edge
//   i_flush                  capture a bubble instead of the incoming instr
//   i_rs_1_num, i_rs_2_num   stage_2 register read addresses
//   rs_1, rs_2               register read data (with bypass)
//   fwd_valid, fwd_rd_num,
//   fwd_val                  pending register write for stage_3 forwarding
//   instret                  64-bit committed instruction count (wraps)
// ---------------------------------------------------------------------------
module stage_5 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_mem_out,
    input  logic [31:0] i_alu_out,
    input  logic [4:0]  i_rd_num,
    input  logic        i_op_type,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [4:0]  i_rs_1_num,
    input  logic [4:0]  i_rs_2_num,
    output logic [31:0] rs_1,
    output logic [31:0] rs_2,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd_num,
    output logic [31:0] fwd_val,
    output logic [63:0] instret
);

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_val;
    logic [31:0] regfile [32];
    logic [63:0] instret_q;
    logic        commit;

    // An instruction leaves MEM/WB on any unstalled edge while it is valid.
    assign commit = wb_valid & ~i_stall;

    // MEM/WB register. The write-back source is selected at capture so the
    // register holds the final value. rd and value load even for bubbles;
    // only wb_valid decides whether anything is committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_val   <= 32'd0;
        end else if (!i_stall) begin
            wb_valid <= i_valid & ~i_flush;
            wb_rd    <= i_rd_num;
            wb_val   <= i_op_type ? i_mem_out : i_alu_out;
        end
    end

    // Register file. Writes to x0 are dropped so entry 0 stays zero, although
    // reads of x0 are forced to zero independently below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= 32'd0;
            end
        end else if (commit && (wb_rd != 5'd0)) begin
            regfile[wb_rd] <= wb_val;
        end
    end

    // Retired-instruction counter. A commit to x0 still counts as retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 64'd0;
        end else if (commit) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    // Read port 1: x0 is hard zero, then the pending write wins over the
    // register file so a reader never sees a stale value.
    always_comb begin
        rs_1 = 32'd0;
        if (i_rs_1_num != 5'd0) begin
            if (wb_valid && (wb_rd == i_rs_1_num)) begin
                rs_1 = wb_val;
            end else begin
                rs_1 = regfile[i_rs_1_num];
            end
        end
    end

    // Read port 2: same priority as read port 1.
    always_comb begin
        rs_2 = 32'd0;
        if (i_rs_2_num != 5'd0) begin
            if (wb_valid && (wb_rd == i_rs_2_num)) begin
                rs_2 = wb_val;
            end else begin
                rs_2 = regfile[i_rs_2_num];
            end
        end
    end

    // A pending write to x0 has no architectural effect, so it is not
    // advertised for forwarding.
    assign fwd_valid  = wb_valid & (wb_rd != 5'd0);
    assign fwd_rd_num = wb_rd;
    assign fwd_val    = wb_val;
    assign instret    = instret_q;

endmodule

// File: tb/tb_stage_5.sv
// ---------------------------------------------------------------------------
// tb_stage_5 -- self-checking bench for stage_5.
//
// The stimulus process drives directed vectors and checks stage-visible
// outputs directly. For every instruction expected to commit it pushes an
// entry (destination, expected read-back, expected instret) into a queue.
// The monitor process watches instret; each increment pops one entry and
// reads the register back through read port 2.
// ---------------------------------------------------------------------------
module tb_stage_5;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_mem_out;
    logic [31:0] i_alu_out;
    logic [4:0]  i_rd_num;
    logic        i_op_type;
    logic        i_stall;
    logic        i_flush;
    logic [4:0]  i_rs_1_num;
    logic [4:0]  i_rs_2_num;
    logic [31:0] rs_1;
    logic [31:0] rs_2;
    logic        fwd_valid;
    logic [4:0]  fwd_rd_num;
    logic [31:0] fwd_val;
    logic [63:0] instret;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] read_val;
        logic [63:0] count;
    } commit_t;

    commit_t expect_q[$];
    int      checks;
    int      failures;

    stage_5 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_mem_out  (i_mem_out),
        .i_alu_out  (i_alu_out),
        .i_rd_num   (i_rd_num),
        .i_op_type  (i_op_type),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_rs_1_num (i_rs_1_num),
        .i_rs_2_num (i_rs_2_num),
        .rs_1       (rs_1),
        .rs_2       (rs_2),
        .fwd_valid  (fwd_valid),
        .fwd_rd_num (fwd_rd_num),
        .fwd_val    (fwd_val),
        .instret    (instret)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; every failure prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drives the stage_4 side inputs; returns immediately.
    task automatic applyStimulus(input logic valid, input logic op_type,
                                 input logic [31:0] mem_out, input logic [31:0] alu_out,
                                 input logic [4:0] rd, input logic stall,
                                 input logic flush);
        i_valid   = valid;
        i_op_type = op_type;
        i_mem_out = mem_out;
        i_alu_out = alu_out;
        i_rd_num  = rd;
        i_stall   = stall;
        i_flush   = flush;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance past a rising edge; inputs change 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCommit(input logic [4:0] rd, input logic [31:0] read_val,
                              input logic [63:0] count);
        commit_t e;
        e.rd       = rd;
        e.read_val = read_val;
        e.count    = count;
        expect_q.push_back(e);
    endtask

    // Monitor: owns read port 2. Samples on the falling edge, away from the
    // active edge, and matches each instret increment to a queued commit.
    initial begin
        logic [63:0] prev;
        commit_t     e;
        prev       = 64'd0;
        i_rs_2_num = 5'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 64'd0;
            end else if (instret != prev) begin
                if (instret != prev + 64'd1) begin
                    checkOutput("instret_step", instret, prev + 64'd1);
                end else if (expect_q.size() == 0) begin
                    checkOutput("unexpected_commit", instret, prev);
                end else begin
                    e = expect_q.pop_front();
                    i_rs_2_num = e.rd;
                    #1;
                    checkOutput("commit_readback", {32'd0, rs_2}, {32'd0, e.read_val});
                    checkOutput("commit_instret", instret, e.count);
                end
                prev = instret;
            end
        end
    end

    // Stimulus and direct checks.
    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        i_rs_1_num = 5'd0;
        applyIdle();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        checkOutput("rst_fwd_rd_num", {59'd0, fwd_rd_num}, 64'd0);
        checkOutput("rst_fwd_val", {32'd0, fwd_val}, 64'd0);
        checkOutput("rst_instret", instret, 64'd0);
        for (int a = 0; a < 32; a += 7) begin
            i_rs_1_num = 5'(a);
            #1;
            checkOutput("rst_rs_1", {32'd0, rs_1}, 64'd0);
        end
        tick();
        rst_n = 1'b1;

        // Load select: memory data wins when op_type=1
        $display("[TB] load select");
        tick();
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 32'h11, 5'd5, 1'b0, 1'b0);
        i_rs_1_num = 5'd5;
        pushCommit(5'd5, 32'hDEADBEEF, 64'd1);
        tick();
        applyIdle();
        #1;
        checkOutput("load_fwd_valid", {63'd0, fwd_valid}, 64'd1);
        checkOutput("load_fwd_rd", {59'd0, fwd_rd_num}, 64'd5);
        checkOutput("load_fwd_val", {32'd0, fwd_val}, 64'hDEADBEEF);
        checkOutput("load_bypass", {32'd0, rs_1}, 64'hDEADBEEF);
        checkOutput("load_instret_pre", instret, 64'd0);
        tick();
        #1;
        checkOutput("load_rf", {32'd0, rs_1}, 64'hDEADBEEF);
        checkOutput("load_instret", instret, 64'd1);
        checkOutput("load_fwd_clear", {63'd0, fwd_valid}, 64'd0);

        // Write to x0: discarded, but still retired
        $display("[TB] x0 write");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h1234, 5'd0, 1'b0, 1'b0);
        i_rs_1_num = 5'd0;
        pushCommit(5'd0, 32'd0, 64'd2);
        tick();
        applyIdle();
        #1;
        checkOutput("x0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        checkOutput("x0_rs_1", {32'd0, rs_1}, 64'd0);
        tick();
        #1;
        checkOutput("x0_instret", instret, 64'd2);
        checkOutput("x0_rs_1_after", {32'd0, rs_1}, 64'd0);

        // Stall holds MEM/WB for three edges
        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h55, 5'd3, 1'b0, 1'b0);
        i_rs_1_num = 5'd3;
        pushCommit(5'd3, 32'h55, 64'd3);
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h99, 5'd4, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            checkOutput("stall_fwd_valid", {63'd0, fwd_valid}, 64'd1);
            checkOutput("stall_fwd_rd", {59'd0, fwd_rd_num}, 64'd3);
            checkOutput("stall_fwd_val", {32'd0, fwd_val}, 64'h55);
            checkOutput("stall_instret", instret, 64'd2);
        end
        applyIdle();
        tick();
        #1;
        checkOutput("stall_release_instret", instret, 64'd3);
        checkOutput("stall_release_rf", {32'd0, rs_1}, 64'h55);
        checkOutput("stall_release_fwd", {63'd0, fwd_valid}, 64'd0);

        // Flush without stall: bubble, rd/val still loaded
        $display("[TB] flush");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h77, 5'd6, 1'b0, 1'b1);
        i_rs_1_num = 5'd6;
        tick();
        applyIdle();
        #1;
        checkOutput("flush_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        checkOutput("flush_fwd_rd", {59'd0, fwd_rd_num}, 64'd6);
        checkOutput("flush_fwd_val", {32'd0, fwd_val}, 64'h77);
        tick();
        #1;
        checkOutput("flush_instret", instret, 64'd3);
        checkOutput("flush_rf", {32'd0, rs_1}, 64'd0);

        // Flush during stall is ignored; held write commits later
        $display("[TB] flush under stall");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h88, 5'd8, 1'b0, 1'b0);
        i_rs_1_num = 5'd8;
        pushCommit(5'd8, 32'h88, 64'd4);
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 32'hAA, 5'd10, 1'b1, 1'b1);
        tick();
        #1;
        checkOutput("sflush_fwd_valid", {63'd0, fwd_valid}, 64'd1);
        checkOutput("sflush_fwd_rd", {59'd0, fwd_rd_num}, 64'd8);
        checkOutput("sflush_fwd_val", {32'd0, fwd_val}, 64'h88);
        checkOutput("sflush_instret", instret, 64'd3);
        applyIdle();
        tick();
        #1;
        checkOutput("sflush_commit_instret", instret, 64'd4);
        checkOutput("sflush_rf", {32'd0, rs_1}, 64'h88);

        // Back-to-back writes to the same register
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'hA, 5'd7, 1'b0, 1'b0);
        i_rs_1_num = 5'd7;
        pushCommit(5'd7, 32'hB, 64'd5);
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 32'hB, 5'd7, 1'b0, 1'b0);
        pushCommit(5'd7, 32'hB, 64'd6);
        #1;
        checkOutput("b2b_first_bypass", {32'd0, rs_1}, 64'hA);
        tick();
        applyIdle();
        #1;
        checkOutput("b2b_second_bypass", {32'd0, rs_1}, 64'hB);
        checkOutput("b2b_mid_instret", instret, 64'd5);
        tick();
        #1;
        checkOutput("b2b_rf", {32'd0, rs_1}, 64'hB);
        checkOutput("b2b_instret", instret, 64'd6);
        checkOutput("b2b_fwd_clear", {63'd0, fwd_valid}, 64'd0);

        // Asynchronous reset discards the pending write
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h1111, 5'd9, 1'b0, 1'b0);
        i_rs_1_num = 5'd9;
        tick();
        applyIdle();
        #1;
        checkOutput("arst_pre_fwd_valid", {63'd0, fwd_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        checkOutput("arst_instret", instret, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        checkOutput("arst_rf9", {32'd0, rs_1}, 64'd0);
        i_rs_1_num = 5'd5;
        #1;
        checkOutput("arst_rf5", {32'd0, rs_1}, 64'd0);
        tick();
        #1;
        checkOutput("arst_instret_after", instret, 64'd0);
        checkOutput("arst_fwd_after", {63'd0, fwd_valid}, 64'd0);

        // Every queued commit must have been observed
        repeat (2) tick();
        checkOutput("queue_drained", 64'(expect_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
